// File: rtl/mem_arb_ctrl.sv
// mem_arb_ctrl: two-port arbiter/sequencer in front of a 4K x 8 single-port
// memory macro. Grants requesters round-robin, drives the memory pins with
// fixed access timing, returns read data and sequences the memory reset.
// Optional build macro: MEM_ARB_FIXED_PRIO_EN gives port 0 fixed priority
// on simultaneous requests instead of round-robin.
module mem_arb_ctrl #(
  parameter int ACC_CYC  = 2,  // cycles the strobe is held per access (1..15)
  parameter int RD_LAT   = 1,  // wait cycles before sampling mem_dout (0..7)
  parameter int INIT_CYC = 4   // cycles mem_rst is held after reset (1..255)
) (
  input  logic        clk,
  input  logic        rst,       // asynchronous, active-low
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [11:0] addr0,
  input  logic [11:0] addr1,
  input  logic [7:0]  wdata0,
  input  logic [7:0]  wdata1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        done0,
  output logic        done1,
  output logic [7:0]  rdata0,
  output logic [7:0]  rdata1,
  output logic        busy,
  output logic        mem_rst,
  output logic        mem_cen,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [11:0] mem_add,
  output logic [7:0]  mem_din,
  input  logic [7:0]  mem_dout
);

  localparam logic [3:0] LP_ACC_LAST  = 4'(ACC_CYC - 1);
  localparam logic [3:0] LP_WAIT_LAST = 4'((RD_LAT > 0) ? (RD_LAT - 1) : 0);
  localparam logic [7:0] LP_INIT_LAST = 8'(INIT_CYC - 1);
  localparam bit         LP_NO_WAIT   = (RD_LAT == 0);

  typedef enum logic [2:0] {
    S_INIT   = 3'd0,
    S_IDLE   = 3'd1,
    S_ACCESS = 3'd2,
    S_WAIT   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_init_cnt;
  logic [3:0]  r_cyc_cnt;
  logic        r_we;
  logic        r_id;

  logic        w_grant;
  logic        w_gnt_id;
  logic        w_we_sel;
  logic [11:0] w_addr_sel;
  logic [7:0]  w_wdata_sel;
  logic        w_init_last;
  logic        w_acc_last;
  logic        w_wait_last;
  logic        w_rd_sample;

`ifdef MEM_ARB_FIXED_PRIO_EN
  // Port 0 wins whenever it is requesting.
  assign w_gnt_id = ~req0;
`else
  logic r_rr_last;

  // A lone request wins; a tie goes to the port that was not served last.
  assign w_gnt_id = (req0 & req1) ? ~r_rr_last : req1;

  // Remember which port was granted most recently for the round-robin tie-break.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rr_last <= 1'b1;
    end else if (w_grant) begin
      r_rr_last <= w_gnt_id;
    end
  end
`endif

  assign w_grant     = (r_state == S_IDLE) && (req0 || req1);
  assign w_we_sel    = w_gnt_id ? we1    : we0;
  assign w_addr_sel  = w_gnt_id ? addr1  : addr0;
  assign w_wdata_sel = w_gnt_id ? wdata1 : wdata0;

  assign w_init_last = (r_init_cnt == LP_INIT_LAST);
  assign w_acc_last  = (r_cyc_cnt == LP_ACC_LAST);
  assign w_wait_last = (r_cyc_cnt == LP_WAIT_LAST);

  // With no wait phase the read data is captured on the last access edge.
  assign w_rd_sample = ((r_state == S_ACCESS) && w_acc_last && !r_we && LP_NO_WAIT) ||
                       ((r_state == S_WAIT) && w_wait_last);

  // State register; reset always restarts the memory init sequence.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_INIT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_INIT:   if (w_init_last) w_state_nxt = S_IDLE;
      S_IDLE:   if (w_grant) w_state_nxt = S_ACCESS;
      S_ACCESS: begin
        if (w_acc_last) begin
          if (r_we || LP_NO_WAIT) w_state_nxt = S_DONE;
          else                    w_state_nxt = S_WAIT;
        end
      end
      S_WAIT:   if (w_wait_last) w_state_nxt = S_DONE;
      S_DONE:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_INIT;
    endcase
  end

  // Requester-side handshake outputs decoded from the current state.
  always_comb begin
    gnt0  = 1'b0;
    gnt1  = 1'b0;
    done0 = 1'b0;
    done1 = 1'b0;
    busy  = 1'b1;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        gnt0 = w_grant & ~w_gnt_id;
        gnt1 = w_grant &  w_gnt_id;
      end
      S_DONE: begin
        done0 = ~r_id;
        done1 =  r_id;
      end
      default: ;
    endcase
  end

  // Init and per-phase cycle counters; the phase counter restarts on every state change.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_init_cnt <= 8'd0;
      r_cyc_cnt  <= 4'd0;
    end else begin
      if ((r_state == S_INIT) && !w_init_last) begin
        r_init_cnt <= r_init_cnt + 8'd1;
      end
      if (w_state_nxt != r_state) begin
        r_cyc_cnt <= 4'd0;
      end else if ((r_state == S_ACCESS) || (r_state == S_WAIT)) begin
        r_cyc_cnt <= r_cyc_cnt + 4'd1;
      end
    end
  end

  // Latch direction and owner of the granted transaction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_we <= 1'b0;
      r_id <= 1'b0;
    end else if (w_grant) begin
      r_we <= w_we_sel;
      r_id <= w_gnt_id;
    end
  end

  // Registered memory pins, driven from the state being entered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_rst <= 1'b1;
      mem_cen <= 1'b1;
      mem_rd  <= 1'b0;
      mem_wr  <= 1'b0;
      mem_add <= 12'h000;
      mem_din <= 8'h00;
    end else begin
      mem_rst <= (w_state_nxt == S_INIT);
      mem_cen <= ~((w_state_nxt == S_ACCESS) || (w_state_nxt == S_WAIT));
      if (w_grant) begin
        mem_add <= w_addr_sel;
        mem_wr  <= w_we_sel;
        mem_rd  <= ~w_we_sel;
        if (w_we_sel) begin
          mem_din <= w_wdata_sel;
        end
      end else if ((r_state == S_ACCESS) && w_acc_last) begin
        mem_rd <= 1'b0;
        mem_wr <= 1'b0;
      end
    end
  end

  // Capture read data into the owning port only; the other port keeps its value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata0 <= 8'h00;
      rdata1 <= 8'h00;
    end else if (w_rd_sample) begin
      if (r_id) rdata1 <= mem_dout;
      else      rdata0 <= mem_dout;
    end
  end

endmodule

// File: tb/tb_mem_arb_ctrl.sv
// Testbench for mem_arb_ctrl: default-parameter instance plus a fast instance
// (ACC_CYC=1, RD_LAT=0), each with its own behavioural 4K x 8 memory.
module tb_mem_arb_ctrl;

  logic        clk;
  logic        rst;

  logic        req0, req1, we0, we1;
  logic [11:0] addr0, addr1;
  logic [7:0]  wdata0, wdata1;
  logic        gnt0, gnt1, done0, done1, busy;
  logic [7:0]  rdata0, rdata1;
  logic        mem_rst, mem_cen, mem_rd, mem_wr;
  logic [11:0] mem_add;
  logic [7:0]  mem_din, mem_dout;

  logic        f_req0, f_req1, f_we0, f_we1;
  logic [11:0] f_addr0, f_addr1;
  logic [7:0]  f_wdata0, f_wdata1;
  logic        f_gnt0, f_gnt1, f_done0, f_done1, f_busy;
  logic [7:0]  f_rdata0, f_rdata1;
  logic        f_mem_rst, f_mem_cen, f_mem_rd, f_mem_wr;
  logic [11:0] f_mem_add;
  logic [7:0]  f_mem_din, f_mem_dout;

  logic [7:0]  mem_a [4096];
  logic [7:0]  mem_f [4096];

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [44:0] RST_EXP = {1'b1, 1'b1, 1'b0, 1'b0, 12'h000, 8'h00,
                                     4'b0000, 8'h00, 8'h00, 1'b1};

  typedef struct {
    bit          port;
    bit          we;
    logic [11:0] addr;
    logic [7:0]  wdata;
    int          lat;
    logic [7:0]  exp_rd;
  } vec_t;

  vec_t vecs [7];
  int   exp_ord [4];

  mem_arb_ctrl u_dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .rdata0(rdata0), .rdata1(rdata1), .busy(busy),
    .mem_rst(mem_rst), .mem_cen(mem_cen), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_add(mem_add), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  mem_arb_ctrl #(.ACC_CYC(1), .RD_LAT(0), .INIT_CYC(4)) u_fast (
    .clk(clk), .rst(rst),
    .req0(f_req0), .req1(f_req1), .we0(f_we0), .we1(f_we1),
    .addr0(f_addr0), .addr1(f_addr1), .wdata0(f_wdata0), .wdata1(f_wdata1),
    .gnt0(f_gnt0), .gnt1(f_gnt1), .done0(f_done0), .done1(f_done1),
    .rdata0(f_rdata0), .rdata1(f_rdata1), .busy(f_busy),
    .mem_rst(f_mem_rst), .mem_cen(f_mem_cen), .mem_rd(f_mem_rd), .mem_wr(f_mem_wr),
    .mem_add(f_mem_add), .mem_din(f_mem_din), .mem_dout(f_mem_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural memories: synchronous write, asynchronous read.
  always @(posedge clk) if (!mem_cen && mem_wr) mem_a[mem_add] <= mem_din;
  always @(posedge clk) if (!f_mem_cen && f_mem_wr) mem_f[f_mem_add] <= f_mem_din;
  assign mem_dout   = mem_a[mem_add];
  assign f_mem_dout = mem_f[f_mem_add];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic g_gnt(input bit f, input bit p);
    return f ? (p ? f_gnt1 : f_gnt0) : (p ? gnt1 : gnt0);
  endfunction
  function automatic logic g_done(input bit f, input bit p);
    return f ? (p ? f_done1 : f_done0) : (p ? done1 : done0);
  endfunction
  function automatic logic [7:0] g_rdata(input bit f, input bit p);
    return f ? (p ? f_rdata1 : f_rdata0) : (p ? rdata1 : rdata0);
  endfunction
  function automatic logic g_cen(input bit f);
    return f ? f_mem_cen : mem_cen;
  endfunction
  function automatic logic g_rd(input bit f);
    return f ? f_mem_rd : mem_rd;
  endfunction
  function automatic logic g_wr(input bit f);
    return f ? f_mem_wr : mem_wr;
  endfunction
  function automatic logic [11:0] g_add(input bit f);
    return f ? f_mem_add : mem_add;
  endfunction
  function automatic logic [7:0] g_din(input bit f);
    return f ? f_mem_din : mem_din;
  endfunction
  function automatic logic [44:0] rst_vec();
    return {mem_rst, mem_cen, mem_rd, mem_wr, mem_add, mem_din,
            gnt0, gnt1, done0, done1, rdata0, rdata1, busy};
  endfunction

  task automatic drive(input bit f, input bit p, input logic r, input logic w,
                       input logic [11:0] a, input logic [7:0] d);
    if (!f) begin
      if (!p) begin req0 = r; we0 = w; addr0 = a; wdata0 = d; end
      else    begin req1 = r; we1 = w; addr1 = a; wdata1 = d; end
    end else begin
      if (!p) begin f_req0 = r; f_we0 = w; f_addr0 = a; f_wdata0 = d; end
      else    begin f_req1 = r; f_we1 = w; f_addr1 = a; f_wdata1 = d; end
    end
  endtask

  // One complete transaction on a single port, started at a falling edge.
  task automatic do_txn(input bit f, input bit p, input bit we, input logic [11:0] a,
                        input logic [7:0] d, input int exp_lat, input int exp_strb,
                        input logic [7:0] exp_rd, input string nm);
    int         cyc;
    int         lat;
    int         strb;
    bit         dual;
    logic [7:0] oth0;
    logic [7:0] din0;
    oth0 = g_rdata(f, !p);
    din0 = g_din(f);
    drive(f, p, 1'b1, we, a, d);
    #1;
    cyc = 0;
    while (!g_gnt(f, p) && cyc < 50) begin
      @(negedge clk); #1; cyc++;
    end
    check({nm, "_gnt"}, 64'(g_gnt(f, p)), 64'(1));
    check({nm, "_gnt_excl"}, 64'(g_gnt(f, !p)), 64'(0));
    @(negedge clk);
    drive(f, p, 1'b0, we, a, d);
    #1;
    check({nm, "_cen"}, 64'(g_cen(f)), 64'(0));
    check({nm, "_add"}, 64'(g_add(f)), 64'(a));
    check({nm, "_din"}, 64'(g_din(f)), we ? 64'(d) : 64'(din0));
    lat  = 1;
    strb = 0;
    dual = 1'b0;
    while (!g_done(f, p) && lat < 50) begin
      if (we ? g_wr(f) : g_rd(f)) strb++;
      if (g_done(f, !p) || (we ? g_rd(f) : g_wr(f))) dual = 1'b1;
      @(negedge clk); #1; lat++;
    end
    if (g_done(f, !p)) dual = 1'b1;
    check({nm, "_latency"}, 64'(lat), 64'(exp_lat));
    check({nm, "_strobe_cycles"}, 64'(strb), 64'(exp_strb));
    check({nm, "_stray_signal"}, 64'(dual), 64'(0));
    if (!we) check({nm, "_rdata"}, 64'(g_rdata(f, p)), 64'(exp_rd));
    check({nm, "_other_rdata"}, 64'(g_rdata(f, !p)), 64'(oth0));
    @(negedge clk);
  endtask

  // Count cycles with mem_rst high after release, plus any grant/done seen meanwhile.
  task automatic init_seq(output int nh, output int ngr, output int nd);
    nh = 0; ngr = 0; nd = 0;
    while (mem_rst && nh < 100) begin
      nh++;
      if (gnt0 || gnt1)   ngr++;
      if (done0 || done1) nd++;
      @(negedge clk);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int nh, ngr, nd, cyc, k, m, d0k, ng, both;
    int ord [4];
    bit r0n, r1n;

    vecs[0] = '{1'b0, 1'b1, 12'h3AA, 8'hAA, 3, 8'h00};
    vecs[1] = '{1'b1, 1'b0, 12'h3AA, 8'h00, 4, 8'hAA};
    vecs[2] = '{1'b0, 1'b1, 12'h000, 8'h5A, 3, 8'h00};
    vecs[3] = '{1'b0, 1'b1, 12'hFFF, 8'hC3, 3, 8'h00};
    vecs[4] = '{1'b1, 1'b0, 12'hFFF, 8'h00, 4, 8'hC3};
    vecs[5] = '{1'b0, 1'b0, 12'h000, 8'h00, 4, 8'h5A};
    vecs[6] = '{1'b1, 1'b0, 12'h000, 8'h00, 4, 8'h5A};
`ifdef MEM_ARB_FIXED_PRIO_EN
    exp_ord = '{0, 0, 0, 0};
`else
    exp_ord = '{0, 1, 0, 1};
`endif
    for (int i = 0; i < 4096; i++) begin
      mem_a[i] = 8'h00;
      mem_f[i] = 8'h00;
    end

    rst = 1'b0;
    drive(0, 0, 0, 0, 12'h0, 8'h0); drive(0, 1, 0, 0, 12'h0, 8'h0);
    drive(1, 0, 0, 0, 12'h0, 8'h0); drive(1, 1, 0, 0, 12'h0, 8'h0);
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check("reset_outputs", 64'(rst_vec()), 64'(RST_EXP));
    check("fast_reset_busy", 64'({f_busy, f_mem_rst}), 64'(2'b11));

    // Port 0 requests during INIT; no grant may appear before mem_rst drops.
    drive(0, 0, 1, 1, 12'h3AA, 8'hAA);
    @(negedge clk);
    rst = 1'b1;
    init_seq(nh, ngr, nd);
    check("init_mem_rst_cycles", 64'(nh), 64'(4));
    check("init_no_grant", 64'(ngr), 64'(0));

    for (int i = 0; i < 7; i++) begin
      do_txn(0, vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata,
             vecs[i].lat, 2, vecs[i].exp_rd, $sformatf("vec%0d", i));
    end

    do_txn(1, 0, 1, 12'h3AA, 8'hAA, 2, 1, 8'h00, "fast_wr");
    do_txn(1, 1, 0, 12'h3AA, 8'h00, 2, 1, 8'hAA, "fast_rd");

    // Request on port 1 arrives while port 0's write is in flight.
    drive(0, 0, 1, 1, 12'h010, 8'h11);
    #1;
    cyc = 0;
    while (!gnt0 && cyc < 50) begin @(negedge clk); #1; cyc++; end
    check("held_gnt0", 64'(gnt0), 64'(1));
    @(posedge clk); #1;
    drive(0, 0, 0, 1, 12'h010, 8'h11);
    drive(0, 1, 1, 0, 12'h010, 8'h00);
    k = 0; d0k = -1;
    while (k < 30) begin
      @(negedge clk); #1; k++;
      if (done0) d0k = k;
      if (gnt1) break;
    end
    check("held_done0_cycle", 64'(d0k), 64'(3));
    check("held_gnt1_cycle", 64'(k), 64'(4));
    @(posedge clk); #1;
    drive(0, 1, 0, 0, 12'h010, 8'h00);
    m = 1;
    @(negedge clk); #1;
    while (!done1 && m < 30) begin @(negedge clk); #1; m++; end
    check("held_rd_latency", 64'(m), 64'(4));
    check("held_rdata1", 64'(rdata1), 64'(8'h11));
    @(negedge clk);

    // Both ports keep requesting; each re-asserts the cycle after its own done.
    drive(0, 0, 1, 1, 12'h3AB, 8'hBB);
    drive(0, 1, 1, 0, 12'h3CD, 8'h00);
    ng = 0; cyc = 0; both = 0;
    while (ng < 4 && cyc < 80) begin
      #1;
      if (gnt0 && gnt1)   both++;
      if (done0 && done1) both++;
      r0n = req0; r1n = req1;
      if (gnt0)      begin ord[ng] = 0; ng++; r0n = 1'b0; end
      else if (gnt1) begin ord[ng] = 1; ng++; r1n = 1'b0; end
      if (done0) r0n = 1'b1;
      if (done1) r1n = 1'b1;
      @(posedge clk); #1;
      req0 = r0n; req1 = r1n;
      @(negedge clk); cyc++;
    end
    req0 = 1'b0; req1 = 1'b0;
    #1;
    cyc = 0;
    while (busy && cyc < 30) begin @(negedge clk); #1; cyc++; end
    check("contend_grant_count", 64'(ng), 64'(4));
    check("contend_exclusive", 64'(both), 64'(0));
    check("contend_drain_idle", 64'(busy), 64'(0));
    for (int i = 0; i < 4; i++) begin
      if (i < ng) check($sformatf("contend_order%0d", i), 64'(ord[i]), 64'(exp_ord[i]));
    end
    @(negedge clk);
    do_txn(0, 1, 0, 12'h3AB, 8'h00, 4, 2, 8'hBB, "rd_3ab");

    // Reset pulse in the middle of a write's access phase.
    drive(0, 0, 1, 1, 12'h3CD, 8'hEE);
    #1;
    cyc = 0;
    while (!gnt0 && cyc < 50) begin @(negedge clk); #1; cyc++; end
    check("abort_gnt0", 64'(gnt0), 64'(1));
    @(posedge clk); #1;
    drive(0, 0, 0, 1, 12'h3CD, 8'hEE);
    #1;
    check("abort_in_access", 64'({mem_wr, mem_cen}), 64'(2'b10));
    #1;
    rst = 1'b0;
    #1;
    check("abort_async_reset", 64'(rst_vec()), 64'(RST_EXP));
    nd = 0;
    repeat (3) begin
      @(negedge clk);
      if (done0 || done1) nd++;
    end
    check("abort_reset_held", 64'(rst_vec()), 64'(RST_EXP));
    rst = 1'b1;
    init_seq(nh, ngr, k);
    check("abort_init_cycles", 64'(nh), 64'(4));
    check("abort_no_done", 64'(nd + k), 64'(0));
    @(negedge clk);
    do_txn(0, 0, 0, 12'h3CD, 8'h00, 4, 2, 8'h00, "rd_3cd_aborted");
    do_txn(0, 1, 0, 12'h3AB, 8'h00, 4, 2, 8'hBB, "rd_3ab_after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
